// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types for the branch/halt controller
package cpu_pkg;

  localparam int ADDR_W = 10;
  localparam int XLEN   = 32;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_BEQ    = 4'd1,
    OP_BNE    = 4'd2,
    OP_BLT    = 4'd3,
    OP_BGE    = 4'd4,
    OP_BLTU   = 4'd5,
    OP_BGEU   = 4'd6,
    OP_JAL    = 4'd7,
    OP_JALR   = 4'd8,
    OP_EBREAK = 4'd9
  } br_op_t;

  typedef logic [1:0] bctl_state_t;

  localparam bctl_state_t ST_RUN   = 2'd0;
  localparam bctl_state_t ST_FLUSH = 2'd1;
  localparam bctl_state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/br_cond.sv
// rtl/br_cond.sv - branch condition, target and alignment evaluation
module br_cond
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int XLEN   = cpu_pkg::XLEN
) (
  input  br_op_t            in_op,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  output logic              cond_taken,
  output logic [ADDR_W-1:0] tgt_word,
  output logic              misaligned
);

  logic [XLEN-1:0] pc_byte;
  logic [XLEN-1:0] byte_tgt;
  logic            is_jalr;
  logic            unused_hi;

  assign is_jalr = (in_op == OP_JALR);
  assign pc_byte = {{(XLEN-ADDR_W-2){1'b0}}, in_pc, 2'b00};

  always_comb begin
    byte_tgt = pc_byte + in_imm;
    if (is_jalr) begin
      byte_tgt = (in_rs1 + in_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    cond_taken = 1'b0;
    case (in_op)
      OP_BEQ:  cond_taken = (in_rs1 == in_rs2);
      OP_BNE:  cond_taken = (in_rs1 != in_rs2);
      OP_BLT:  cond_taken = ($signed(in_rs1) <  $signed(in_rs2));
      OP_BGE:  cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
      OP_BLTU: cond_taken = (in_rs1 <  in_rs2);
      OP_BGEU: cond_taken = (in_rs1 >= in_rs2);
      OP_JAL:  cond_taken = 1'b1;
      OP_JALR: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // Bits above the word address are dropped so targets wrap around the PC space.
  assign tgt_word   = byte_tgt[ADDR_W+1:2];
  assign unused_hi  = ^byte_tgt[XLEN-1:ADDR_W+2];
  assign misaligned = cond_taken && (byte_tgt[1] || (!is_jalr && byte_tgt[0]));

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - redirect/flush/halt FSM driving the PC mux controls
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = cpu_pkg::ADDR_W,
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  br_op_t            in_op,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              resume,
  output logic              taken,
  output logic [ADDR_W-1:0] br_addr,
  output logic              halting,
  output logic              err,
  output logic [15:0]       br_count
);

  bctl_state_t       state;
  logic [3:0]        flush_cnt;
  logic              cond_taken;
  logic              misaligned;
  logic [ADDR_W-1:0] tgt_word;
  logic              accept;

  br_cond #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) u_br_cond (
    .in_op      (in_op),
    .in_pc      (in_pc),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .cond_taken (cond_taken),
    .tgt_word   (tgt_word),
    .misaligned (misaligned)
  );

  // Moore outputs: decode handshake never depends on in_valid.
  assign in_ready = (state == ST_RUN);
  assign halting  = (state == ST_HALT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
      taken     <= 1'b0;
      br_addr   <= '0;
      err       <= 1'b0;
      br_count  <= 16'd0;
    end else begin
      taken <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (in_op == OP_EBREAK) begin
              state <= ST_HALT;
            end else if (misaligned) begin
              state <= ST_HALT;
              err   <= 1'b1;
            end else if (cond_taken) begin
              state     <= ST_FLUSH;
              flush_cnt <= 4'(FLUSH_CYCLES);
              taken     <= 1'b1;
              br_addr   <= tgt_word;
              if (br_count != 16'hFFFF) begin
                br_count <= br_count + 16'd1;
              end
            end
          end
        end
        ST_FLUSH: begin
          // Leave on the edge where the counter would reach zero, giving exactly FLUSH_CYCLES stall cycles.
          flush_cnt <= flush_cnt - 4'd1;
          if (flush_cnt <= 4'd1) begin
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state <= ST_RUN;
            err   <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed scoreboard bench for branch_ctrl
module tb_branch_ctrl;
  import cpu_pkg::*;

  typedef struct {
    logic        t;
    logic [9:0]  a;
    logic        h;
    logic        e;
    logic [15:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  br_op_t      in_op = OP_NOP;
  logic [9:0]  in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        resume = 1'b0;
  logic        taken;
  logic [9:0]  br_addr;
  logic        halting;
  logic        err;
  logic [15:0] br_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_ctrl #(.ADDR_W(10), .XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_pc    (in_pc),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .resume   (resume),
    .taken    (taken),
    .br_addr  (br_addr),
    .halting  (halting),
    .err      (err),
    .br_count (br_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_taken"},   {31'd0, taken},   {31'd0, e.t});
      chk({tag, "_br_addr"}, {22'd0, br_addr}, {22'd0, e.a});
      chk({tag, "_halting"}, {31'd0, halting}, {31'd0, e.h});
      chk({tag, "_err"},     {31'd0, err},     {31'd0, e.e});
      chk({tag, "_count"},   {16'd0, br_count}, {16'd0, e.c});
    end
  endtask

  task automatic send_op(input string tag, input br_op_t op, input logic [9:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic et, input logic [9:0] ea, input logic eh, input logic ee,
                         input logic [15:0] ec);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    end
    in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    e.t = et; e.a = ea; e.h = eh; e.e = ee; e.c = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_taken",   {31'd0, taken},   32'd0);
    chk("rst_halting", {31'd0, halting}, 32'd0);
    chk("rst_br_addr", {22'd0, br_addr}, 32'd0);
    chk("rst_ready",   {31'd0, in_ready}, 32'd1);
    chk("rst_count",   {16'd0, br_count}, 32'd0);
    chk("rst_err",     {31'd0, err},     32'd0);

    // BEQ taken: byte 16+8=24 -> word 6, then two stall cycles.
    send_op("beq", OP_BEQ, 10'd4, 32'd7, 32'd7, 32'd8, 1'b1, 10'd6, 1'b0, 1'b0, 16'd1);
    chk("beq_ready_c0", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("beq_taken_c1", {31'd0, taken},    32'd0);
    chk("beq_ready_c1", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("beq_ready_c2", {31'd0, in_ready}, 32'd1);

    send_op("bne", OP_BNE, 10'd8, 32'd7, 32'd7, 32'd8, 1'b0, 10'd6, 1'b0, 1'b0, 16'd1);
    chk("bne_ready", {31'd0, in_ready}, 32'd1);

    // -1 < 1 signed, but 0xFFFFFFFF > 1 unsigned; byte 40+12=52 -> word 13.
    send_op("blt",  OP_BLT,  10'd10, 32'hFFFF_FFFF, 32'd1, 32'd12, 1'b1, 10'd13, 1'b0, 1'b0, 16'd2);
    send_op("bltu", OP_BLTU, 10'd10, 32'hFFFF_FFFF, 32'd1, 32'd12, 1'b0, 10'd13, 1'b0, 1'b0, 16'd2);
    send_op("bge",  OP_BGE,  10'd10, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 10'd9, 1'b0, 1'b0, 16'd3);

    // JAL from 1023: byte 4092+4=4096 wraps to word 0.
    send_op("jal_wrap", OP_JAL, 10'd1023, 32'd0, 32'd0, 32'd4, 1'b1, 10'd0, 1'b0, 1'b0, 16'd4);
    send_op("jalr", OP_JALR, 10'd50, 32'd100, 32'd0, 32'd1, 1'b1, 10'd25, 1'b0, 1'b0, 16'd5);

    send_op("ebreak", OP_EBREAK, 10'd3, 32'd0, 32'd0, 32'd0, 1'b0, 10'd25, 1'b1, 1'b0, 16'd5);
    chk("ebreak_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_op = OP_JAL; in_pc = 10'd0; in_imm = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halt_hold_taken", {31'd0, taken},    32'd0);
      chk("halt_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("halt_hold_count", {16'd0, br_count}, 32'd5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("resume_halting", {31'd0, halting}, 32'd0);
    chk("resume_ready",   {31'd0, in_ready}, 32'd1);

    // Byte target 2 is not word aligned: halt with err, no redirect.
    send_op("misalign", OP_JAL, 10'd0, 32'd0, 32'd0, 32'd2, 1'b0, 10'd25, 1'b1, 1'b1, 16'd5);
    @(negedge clk);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("mis_resume_err",     {31'd0, err},     32'd0);
    chk("mis_resume_halting", {31'd0, halting}, 32'd0);

    // Reset one cycle into the flush window.
    send_op("pre_rst", OP_BEQ, 10'd0, 32'd1, 32'd1, 32'd4, 1'b1, 10'd1, 1'b0, 1'b0, 16'd6);
    @(posedge clk); #1;
    chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready",   {31'd0, in_ready}, 32'd1);
    chk("midrst_count",   {16'd0, br_count}, 32'd0);
    chk("midrst_taken",   {31'd0, taken},    32'd0);
    chk("midrst_br_addr", {22'd0, br_addr},  32'd0);
    chk("midrst_halting", {31'd0, halting},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_op("post_rst", OP_JAL, 10'd2, 32'd0, 32'd0, 32'd8, 1'b1, 10'd4, 1'b0, 1'b0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
